// File: rtl/lock_pkg.sv
// Shared key codes, sequencer states and default sizing for the door-lock front end.
package lock_pkg;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  localparam int DEF_MAX_DIGITS     = 6;
  localparam int DEF_MIN_DIGITS     = 4;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_LOCKOUT_CYCLES = 1000;
  localparam int DEF_UNLOCK_CYCLES  = 500;

  typedef enum logic [2:0] {
    ENTRY,
    CHECK,
    UNLOCKED,
    SET_ENTRY,
    COMMIT,
    LOCKOUT
  } state_t;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that parks at zero; zero is the expiry condition.
module lock_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // Load has priority; otherwise count down and hold once zero is reached.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/keypad_entry_sequencer.sv
// Turns debounced keypad strobes into digit-write, compare and commit control,
// and owns the unlock window and the failed-attempt lockout.
module keypad_entry_sequencer
  import lock_pkg::*;
#(
  parameter int MAX_DIGITS     = DEF_MAX_DIGITS,
  parameter int MIN_DIGITS     = DEF_MIN_DIGITS,
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  correct,
  output logic [3:0]            data,
  output logic [MAX_DIGITS-1:0] cs,
  output logic                  wr,
  output logic                  compare,
  output logic                  clear_input,
  output logic [2:0]            digit_count,
  output logic                  unlocked,
  output logic                  locked_out,
  output logic                  error
);

  localparam int TMR_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
  // Loaded with N-1 so the guarded state lasts exactly N clocks including the exit edge.
  localparam logic [TMR_W-1:0] LOCK_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] UNLOCK_LOAD = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [2:0]       MAX_CNT     = 3'(MAX_DIGITS);
  localparam logic [2:0]       MIN_CNT     = 3'(MIN_DIGITS);

  state_t                  r_state;
  logic                    r_check_phase;
  logic                    r_post_rst;
  logic [FAIL_W-1:0]       r_fail_cnt;
  logic [3:0]              r_data;
  logic [MAX_DIGITS-1:0]   r_cs;
  logic                    r_wr;
  logic                    r_compare;
  logic                    r_clear_input;
  logic [2:0]              r_digit_count;
  logic                    r_unlocked;
  logic                    r_locked_out;
  logic                    r_error;

  logic                    w_is_digit;
  logic                    w_is_star;
  logic                    w_is_hash;
  logic                    w_tmr_load;
  logic [TMR_W-1:0]        w_tmr_val;
  logic                    w_tmr_expired;

  assign w_is_digit = key_valid && (key_code <= 4'd9);
  assign w_is_star  = key_valid && (key_code == KEY_STAR);
  assign w_is_hash  = key_valid && (key_code == KEY_HASH);

  // Timer reloads: opening the door, entering lockout, and any key while unlocked.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = UNLOCK_LOAD;
    case (r_state)
      CHECK: begin
        if (r_check_phase) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = correct ? UNLOCK_LOAD : LOCK_LOAD;
        end
      end
      UNLOCKED: w_tmr_load = key_valid;
      default:  w_tmr_load = 1'b0;
    endcase
  end

  lock_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expired  (w_tmr_expired)
  );

  // Sequencer FSM; every output is a register and the strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ENTRY;
      r_check_phase <= 1'b0;
      r_post_rst    <= 1'b1;
      r_fail_cnt    <= '0;
      r_data        <= '0;
      r_cs          <= '0;
      r_wr          <= 1'b0;
      r_compare     <= 1'b0;
      r_clear_input <= 1'b0;
      r_digit_count <= '0;
      r_unlocked    <= 1'b0;
      r_locked_out  <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_cs          <= '0;
      r_wr          <= 1'b0;
      r_compare     <= 1'b0;
      r_error       <= 1'b0;
      r_clear_input <= r_post_rst;
      r_post_rst    <= 1'b0;
      case (r_state)
        ENTRY, SET_ENTRY: begin
          if (r_state == SET_ENTRY && w_tmr_expired) begin
            // Unlock window closed before a commit: drop the partial password.
            r_state       <= ENTRY;
            r_unlocked    <= 1'b0;
            r_clear_input <= 1'b1;
            r_digit_count <= '0;
          end else if (w_is_digit) begin
            if (r_digit_count < MAX_CNT) begin
              r_data        <= key_code;
              r_cs          <= MAX_DIGITS'(1) << r_digit_count;
              r_digit_count <= r_digit_count + 3'd1;
            end else begin
              r_error <= 1'b1;
            end
          end else if (w_is_star) begin
            if (r_state == ENTRY) begin
              r_compare     <= 1'b1;
              r_check_phase <= 1'b0;
              r_state       <= CHECK;
            end else if (r_digit_count >= MIN_CNT) begin
              r_wr    <= 1'b1;
              r_cs    <= '1;
              r_state <= COMMIT;
            end else begin
              r_error <= 1'b1;
            end
          end else if (w_is_hash) begin
            r_clear_input <= 1'b1;
            r_digit_count <= '0;
          end
        end
        CHECK: begin
          // First cycle gives the comparator time to answer; second samples it.
          if (!r_check_phase) begin
            r_check_phase <= 1'b1;
          end else begin
            r_clear_input <= 1'b1;
            r_digit_count <= '0;
            if (correct) begin
              r_state    <= UNLOCKED;
              r_unlocked <= 1'b1;
              r_fail_cnt <= '0;
            end else if (r_fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
              r_state      <= LOCKOUT;
              r_locked_out <= 1'b1;
              r_fail_cnt   <= r_fail_cnt + FAIL_W'(1);
            end else begin
              r_state    <= ENTRY;
              r_fail_cnt <= r_fail_cnt + FAIL_W'(1);
            end
          end
        end
        UNLOCKED: begin
          // A key keeps the door open (timer reload), so it wins over expiry.
          if (key_valid) begin
            if (w_is_hash) begin
              r_state       <= SET_ENTRY;
              r_clear_input <= 1'b1;
              r_digit_count <= '0;
            end
          end else if (w_tmr_expired) begin
            r_state    <= ENTRY;
            r_unlocked <= 1'b0;
          end
        end
        COMMIT: begin
          r_state       <= ENTRY;
          r_clear_input <= 1'b1;
          r_digit_count <= '0;
          r_unlocked    <= 1'b0;
        end
        LOCKOUT: begin
          r_error <= key_valid && (key_code <= KEY_HASH);
          if (w_tmr_expired) begin
            r_state      <= ENTRY;
            r_locked_out <= 1'b0;
            r_fail_cnt   <= '0;
          end
        end
        default: r_state <= ENTRY;
      endcase
    end
  end

  assign data        = r_data;
  assign cs          = r_cs;
  assign wr          = r_wr;
  assign compare     = r_compare;
  assign clear_input = r_clear_input;
  assign digit_count = r_digit_count;
  assign unlocked    = r_unlocked;
  assign locked_out  = r_locked_out;
  assign error       = r_error;

endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// Scenario bench for the keypad entry sequencer with random digits and keys.
module tb_keypad_entry_sequencer;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'hF;
  logic       correct = 1'b0;
  logic [3:0] data;
  logic [5:0] cs;
  logic       wr, compare, clear_input, unlocked, locked_out, error;
  logic [2:0] digit_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  keypad_entry_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .correct     (correct),
    .data        (data),
    .cs          (cs),
    .wr          (wr),
    .compare     (compare),
    .clear_input (clear_input),
    .digit_count (digit_count),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .error       (error)
  );

  // Advance one clock and look at outputs 1 ns after the edge; global invariants ride along.
  task automatic step();
    @(posedge clk);
    #1;
    checks++;
    if (wr && compare) begin
      errors++;
      $display("FAIL wr_compare_excl: wr=%b compare=%b required not both", wr, compare);
    end
    checks++;
    if (!wr && ($countones(cs) > 1)) begin
      errors++;
      $display("FAIL cs_onehot: cs=%b required at most one bit outside commit", cs);
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
    key_code  = 4'hF;
    $display("key %h: cs=%b data=%h cnt=%0d cmp=%b wr=%b clr=%b err=%b unl=%b lck=%b",
             k, cs, data, digit_count, compare, wr, clear_input, error, unlocked, locked_out);
  endtask

  // One full attempt: n random digits, star, then the two checking cycles.
  task automatic attempt(input int n, input logic c);
    for (int i = 0; i < n; i++) press(4'($urandom_range(0, 9)));
    correct = c;
    press(KEY_STAR);
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if ({data, cs, wr, compare, clear_input, digit_count, unlocked, locked_out, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h cs=%b wr=%b cmp=%b clr=%b cnt=%0d unl=%b lck=%b err=%b required all 0",
               data, cs, wr, compare, clear_input, digit_count, unlocked, locked_out, error);
    end
    reset = 1'b1;
    step();
    checks++;
    if (clear_input !== 1'b1) begin errors++; $display("FAIL reset_clear_pulse: clear_input=%b required 1", clear_input); end
    step();
    checks++;
    if (clear_input !== 1'b0) begin errors++; $display("FAIL reset_clear_single: clear_input=%b required 0", clear_input); end
  endtask

  task automatic test_unlock();
    logic [3:0] d;
    logic [5:0] exp_cs;
    for (int i = 0; i < 4; i++) begin
      d = 4'($urandom_range(0, 9));
      exp_cs = 6'd1 << i;
      press(d);
      checks++;
      if (cs !== exp_cs || data !== d || digit_count !== 3'(i + 1)) begin
        errors++;
        $display("FAIL unlock_digit%0d: cs=%b data=%h cnt=%0d required cs=%b data=%h cnt=%0d",
                 i, cs, data, digit_count, exp_cs, d, i + 1);
      end
    end
    correct = 1'b1;
    press(KEY_STAR);
    checks++;
    if (compare !== 1'b1 || cs !== 6'd0) begin errors++; $display("FAIL unlock_compare: compare=%b cs=%b required 1 and 000000", compare, cs); end
    step();
    checks++;
    if (compare !== 1'b0 || unlocked !== 1'b0) begin errors++; $display("FAIL unlock_wait: compare=%b unlocked=%b required 0 0", compare, unlocked); end
    step();
    checks++;
    if (unlocked !== 1'b1 || digit_count !== 3'd0 || clear_input !== 1'b1) begin
      errors++;
      $display("FAIL unlock_open: unlocked=%b cnt=%0d clr=%b required 1 0 1", unlocked, digit_count, clear_input);
    end
  endtask

  task automatic test_commit();
    logic [3:0] keys [5];
    keys = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5};
    press(KEY_HASH);
    checks++;
    if (clear_input !== 1'b1 || unlocked !== 1'b1) begin errors++; $display("FAIL commit_hash: clr=%b unlocked=%b required 1 1", clear_input, unlocked); end
    for (int i = 0; i < 5; i++) begin
      press(keys[i]);
      checks++;
      if (cs !== (6'd1 << i) || data !== keys[i]) begin
        errors++;
        $display("FAIL commit_digit%0d: cs=%b data=%h required cs=%b data=%h", i, cs, data, 6'd1 << i, keys[i]);
      end
    end
    press(KEY_STAR);
    checks++;
    if (wr !== 1'b1 || cs !== 6'b111111 || compare !== 1'b0) begin
      errors++;
      $display("FAIL commit_wr: wr=%b cs=%b cmp=%b required 1 111111 0", wr, cs, compare);
    end
    step();
    checks++;
    if (wr !== 1'b0 || cs !== 6'd0 || clear_input !== 1'b1 || unlocked !== 1'b0 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL commit_after: wr=%b cs=%b clr=%b unl=%b cnt=%0d required 0 000000 1 0 0", wr, cs, clear_input, unlocked, digit_count);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] last_d;
    for (int i = 0; i < 6; i++) begin
      last_d = 4'($urandom_range(0, 9));
      press(last_d);
    end
    checks++;
    if (digit_count !== 3'd6) begin errors++; $display("FAIL overflow_full: cnt=%0d required 6", digit_count); end
    press(4'($urandom_range(0, 9)));
    checks++;
    if (error !== 1'b1 || cs !== 6'd0 || digit_count !== 3'd6 || data !== last_d) begin
      errors++;
      $display("FAIL overflow_7th: err=%b cs=%b cnt=%0d data=%h required 1 000000 6 %h", error, cs, digit_count, data, last_d);
    end
    step();
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL overflow_err_pulse: err=%b required 0", error); end
    press(KEY_HASH);
    checks++;
    if (clear_input !== 1'b1 || digit_count !== 3'd0) begin errors++; $display("FAIL overflow_hash: clr=%b cnt=%0d required 1 0", clear_input, digit_count); end
  endtask

  // Random digits, hashes and unused codes in ENTRY against a count/data model.
  task automatic test_random_entry();
    int cnt;
    logic [3:0] k, exp_data;
    logic [5:0] exp_cs;
    logic exp_err, exp_clr;
    exp_data = 4'($urandom_range(0, 9));
    press(exp_data);
    cnt = 1;
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) step();
      k = 4'($urandom_range(0, 15));
      if (k == KEY_STAR) k = 4'hC;
      exp_cs = 6'd0; exp_err = 1'b0; exp_clr = 1'b0;
      if (k <= 4'd9) begin
        if (cnt < 6) begin exp_cs = 6'd1 << cnt; exp_data = k; cnt++; end
        else exp_err = 1'b1;
      end else if (k == KEY_HASH) begin
        exp_clr = 1'b1; cnt = 0;
      end
      press(k);
      checks++;
      if (cs !== exp_cs || error !== exp_err || clear_input !== exp_clr || digit_count !== 3'(cnt) || data !== exp_data) begin
        errors++;
        $display("FAIL rand_entry%0d key=%h: cs=%b err=%b clr=%b cnt=%0d data=%h required %b %b %b %0d %h",
                 t, k, cs, error, clear_input, digit_count, data, exp_cs, exp_err, exp_clr, cnt, exp_data);
      end
    end
    press(KEY_HASH);
  endtask

  task automatic test_set_entry_short();
    int elapsed;
    attempt(4, 1'b1);
    press(KEY_HASH);
    elapsed = 0;
    press(4'd1); elapsed++;
    press(4'd2); elapsed++;
    press(KEY_STAR); elapsed++;
    checks++;
    if (error !== 1'b1 || wr !== 1'b0 || unlocked !== 1'b1) begin
      errors++;
      $display("FAIL set_short_star: err=%b wr=%b unl=%b required 1 0 1", error, wr, unlocked);
    end
    while (unlocked === 1'b1 && elapsed < 600) begin
      step();
      elapsed++;
      checks++;
      if (wr !== 1'b0) begin errors++; $display("FAIL set_idle_wr: wr=%b required 0 at cycle %0d", wr, elapsed); end
    end
    checks++;
    if (elapsed !== 500) begin errors++; $display("FAIL set_expiry_time: closed after %0d cycles required 500", elapsed); end
    press(KEY_HASH);
  endtask

  task automatic test_lockout();
    int n;
    logic kv;
    logic [3:0] kc;
    for (int a = 0; a < 3; a++) begin
      attempt($urandom_range(1, 6), 1'b0);
      checks++;
      if (locked_out !== (a == 2) || unlocked !== 1'b0 || clear_input !== 1'b1 || digit_count !== 3'd0) begin
        errors++;
        $display("FAIL lockout_attempt%0d: lck=%b unl=%b clr=%b cnt=%0d required %b 0 1 0", a, locked_out, unlocked, clear_input, digit_count, a == 2);
      end
    end
    n = 1;
    while (n < 2000) begin
      kv = (n < 990) && ($urandom_range(0, 3) == 0);
      kc = 4'($urandom_range(0, 15));
      key_valid = kv;
      key_code  = kc;
      step();
      key_valid = 1'b0;
      checks++;
      if (error !== (kv && kc <= 4'hB) || cs !== 6'd0 || compare !== 1'b0 || wr !== 1'b0 || clear_input !== 1'b0) begin
        errors++;
        $display("FAIL lockout_key n=%0d kv=%b code=%h: err=%b cs=%b cmp=%b wr=%b clr=%b required err=%b others 0",
                 n, kv, kc, error, cs, compare, wr, clear_input, kv && kc <= 4'hB);
      end
      if (locked_out !== 1'b1) break;
      n++;
    end
    checks++;
    if (n !== 1000) begin errors++; $display("FAIL lockout_length: locked_out high %0d cycles required 1000", n); end
    attempt(2, 1'b0);
    checks++;
    if (locked_out !== 1'b0) begin errors++; $display("FAIL lockout_fail_reset: lck=%b required 0", locked_out); end
  endtask

  task automatic test_reset_mid_check();
    attempt(3, 1'b0);
    for (int i = 0; i < 3; i++) press(4'($urandom_range(0, 9)));
    correct = 1'b0;
    press(KEY_STAR);
    reset = 1'b0;
    step();
    checks++;
    if ({data, cs, wr, compare, clear_input, digit_count, unlocked, locked_out, error} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: data=%h cs=%b wr=%b cmp=%b clr=%b cnt=%0d unl=%b lck=%b err=%b required all 0",
               data, cs, wr, compare, clear_input, digit_count, unlocked, locked_out, error);
    end
    reset = 1'b1;
    step();
    checks++;
    if (clear_input !== 1'b1) begin errors++; $display("FAIL midreset_clear: clr=%b required 1", clear_input); end
    step();
    checks++;
    if (clear_input !== 1'b0 || locked_out !== 1'b0) begin errors++; $display("FAIL midreset_idle: clr=%b lck=%b required 0 0", clear_input, locked_out); end
    attempt(4, 1'b0);
    checks++;
    if (locked_out !== 1'b0 || unlocked !== 1'b0) begin
      errors++;
      $display("FAIL midreset_failcnt: lck=%b unl=%b required 0 0 after one wrong attempt", locked_out, unlocked);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unlock();
    test_commit();
    test_overflow();
    test_random_entry();
    test_set_entry_short();
    test_lockout();
    test_reset_mid_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
